mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter LEN, default 32, meaning operand and HI/LO register width.
REQ-002 The block SHALL have parameter NB_OP, default 3, meaning width of the operation code.
REQ-003 The block SHALL have port i_clk, input, 1, system clock; all state updates on posedge.
REQ-004 The block SHALL have port i_rst, input, 1, synchronous, active-low reset.
REQ-005 The block SHALL have port i_enable, input, 1, pipeline enable; low freezes all state.
REQ-006 The block SHALL have port i_start, input, 1, operation request from decode.
REQ-007 The block SHALL have port i_op, input, NB_OP, operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-008 The block SHALL have port i_rs_data, input, LEN, operand A from register file read port 1 (dividend/multiplicand/MT source).
REQ-009 The block SHALL have port i_rt_data, input, LEN, operand B from register file read port 2 (divisor/multiplier).
REQ-010 The block SHALL have port o_hi, output, LEN, HI register.
REQ-011 The block SHALL have port o_lo, output, LEN, LO register.
REQ-012 The block SHALL have port o_busy, output, 1, registered; high while a MULT/DIV is in progress (pipeline stall request).
REQ-013 The block SHALL have port o_done, output, 1, registered one-cycle pulse when HI/LO take a MULT/DIV result.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX; only IDLE accepts requests.
REQ-015 Accept SHALL occur at a posedge where state==IDLE, i_enable=1, i_start=1; operands are latched at that edge.
REQ-016 Accepted MULT/MULTU SHALL go to MUL, DIV/DIVU to DIV, both with a 5-bit iteration counter cleared to 0.
REQ-017 MUL/DIV SHALL perform one radix-2 iteration per enabled cycle on operand magnitudes (shift-add multiply, restoring divide), 32 iterations, then go to FIX.
REQ-018 FIX SHALL apply sign correction for signed ops, write o_hi/o_lo, set o_done=1 for exactly one cycle, and return to IDLE.
REQ-019 o_busy SHALL be 1 from the accept edge until the edge that writes HI/LO; total latency is 33 enabled cycles (accept edge N -> HI/LO valid and o_busy=0 after edge N+33).
REQ-020 MULT/MULTU SHALL produce the full 2*LEN product: HI = upper LEN bits, LO = lower LEN bits, two's complement for MULT.
REQ-021 DIV/DIVU SHALL produce LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder sign equals dividend sign.
REQ-022 Divide by zero (either DIV or DIVU) SHALL give LO = 0xFFFFFFFF, HI = i_rs_data, with normal 33-cycle latency.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0x00000000.
REQ-024 MTHI/MTLO accepted in IDLE SHALL write i_rs_data to HI/LO at the accept edge, with no busy and no done.
REQ-025 i_start while state != IDLE SHALL be ignored (no queueing); no-op codes SHALL change nothing.
REQ-026 i_enable=0 SHALL hold state, counter, partial results, o_hi, o_lo, o_busy; o_done SHALL drop to 0 and the pending pulse SHALL still occur once, on the FIX edge when enable returns.
REQ-027 o_hi/o_lo SHALL hold their previous values throughout MUL/DIV until the FIX edge.

Reset
REQ-028 At a posedge with i_rst=0: state=IDLE, counter=0, o_hi=0, o_lo=0, o_busy=0, o_done=0, internal operands cleared; this overrides i_enable and i_start.
REQ-029 Reset mid-operation SHALL abort it with no HI/LO update and no o_done pulse.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, o_done high one cycle, o_busy high exactly 33 cycles.
REQ-031 MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU 100 / 7 with i_enable low 5 cycles mid-op -> o_busy high 38 cycles, LO=14, HI=2; second i_start during busy ignored.
REQ-034 MULTU started, i_rst low at cycle 10 -> o_hi=o_lo=0, o_busy=0, no o_done; then MTHI 0x12345678 -> o_hi=0x12345678 after one edge, o_busy stays 0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the decode stage and the HI/LO multiply/divide
// unit.
//
// Signals
//   i_enable  : pipeline enable (low freezes the unit)
//   i_start   : operation request
//   i_op      : operation code (NB_OP bits)
//   i_rs_data : operand A (dividend / multiplicand / MTHI-MTLO source)
//   i_rt_data : operand B (divisor / multiplier)
//   o_hi      : HI register
//   o_lo      : LO register
//   o_busy    : MULT/DIV in progress (stall request)
//   o_done    : one-cycle pulse when HI/LO take a MULT/DIV result
//
// Modports
//   master : requester (decode stage / testbench)
//   slave  : the multiply/divide unit
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int LEN   = 32,
    parameter int NB_OP = 3
);
    logic             i_enable;
    logic             i_start;
    logic [NB_OP-1:0] i_op;
    logic [LEN-1:0]   i_rs_data;
    logic [LEN-1:0]   i_rt_data;
    logic [LEN-1:0]   o_hi;
    logic [LEN-1:0]   o_lo;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_enable, i_start, i_op, i_rs_data, i_rt_data,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_enable, i_start, i_op, i_rs_data, i_rt_data,
        output o_hi, o_lo, o_busy, o_done
    );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative HI/LO multiply/divide unit. MULT/MULTU use a radix-2 shift-add
// multiplier, DIV/DIVU a radix-2 restoring divider, both on operand
// magnitudes with sign fix-up in a final FIX cycle. Latency is 33 enabled
// cycles from the accept edge to HI/LO valid. MTHI/MTLO write in one edge.
//
// Ports
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous, active-low reset
//   bus   : mult_div_unit_if.slave (request, operands, HI/LO, busy, done)
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int LEN   = 32,
    parameter int NB_OP = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mult_div_unit_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(0);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(1);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(2);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(3);
    localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(4);
    localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(5);

    localparam logic [4:0] CNT_LAST = 5'(LEN - 1);

    logic [1:0]     state;
    logic [4:0]     cnt;
    // m_reg: multiplicand magnitude (MUL) or divisor magnitude (DIV).
    logic [LEN-1:0] m_reg;
    // {p_hi, p_lo}: running product (MUL) or {remainder, dividend/quotient} (DIV).
    logic [LEN-1:0] p_hi;
    logic [LEN-1:0] p_lo;
    logic [LEN-1:0] a_raw;       // original dividend, returned as HI on divide by zero
    logic           neg_main;    // negate product (MUL) or quotient (DIV)
    logic           neg_rem;     // negate remainder (DIV)
    logic           div_zero;
    logic           is_div;
    logic [LEN-1:0] hi_q;
    logic [LEN-1:0] lo_q;
    logic           busy_q;
    logic           done_q;

    // ---------------- operand preparation at accept ----------------
    logic           op_signed;
    logic           sign_a;
    logic           sign_b;
    logic [LEN-1:0] abs_a;
    logic [LEN-1:0] abs_b;

    assign op_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
    assign sign_a    = op_signed & bus.i_rs_data[LEN-1];
    assign sign_b    = op_signed & bus.i_rt_data[LEN-1];
    assign abs_a     = sign_a ? (~bus.i_rs_data + 1'b1) : bus.i_rs_data;
    assign abs_b     = sign_b ? (~bus.i_rt_data + 1'b1) : bus.i_rt_data;

    // ---------------- one multiply iteration ----------------
    // Add the multiplicand when the current multiplier bit is set, then shift
    // the whole {sum, p_lo} pair right; the carry lands in the top of p_hi.
    logic [LEN:0] mul_sum;
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_reg} : '0);

    // ---------------- one restoring-divide iteration ----------------
    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; a clear borrow bit means the quotient bit is 1.
    logic [LEN:0] div_shift;
    logic [LEN:0] div_diff;
    logic         div_ok;
    assign div_shift = {p_hi, p_lo[LEN-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};
    assign div_ok    = ~div_diff[LEN];

    // ---------------- sign correction for the FIX edge ----------------
    logic [2*LEN-1:0] prod_raw;
    logic [2*LEN-1:0] prod_fix;
    logic [LEN-1:0]   quot_fix;
    logic [LEN-1:0]   rem_fix;
    logic [LEN-1:0]   hi_res;
    logic [LEN-1:0]   lo_res;

    assign prod_raw = {p_hi, p_lo};
    assign prod_fix = neg_main ? (~prod_raw + 1'b1) : prod_raw;
    assign quot_fix = neg_main ? (~p_lo + 1'b1) : p_lo;
    assign rem_fix  = neg_rem  ? (~p_hi + 1'b1) : p_hi;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        hi_res = prod_fix[2*LEN-1:LEN];
        lo_res = prod_fix[LEN-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_res = a_raw;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quot_fix;
            end
        end
    end

    // ---------------- state machine and datapath ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            m_reg    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            a_raw    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!bus.i_enable) begin
            // Frozen pipeline: everything holds except the done pulse, which
            // is re-issued on the FIX edge once enable returns.
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        case (bus.i_op)
                            OP_MULT, OP_MULTU: begin
                                state    <= ST_MUL;
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                                m_reg    <= abs_a;
                                p_hi     <= '0;
                                p_lo     <= abs_b;
                                a_raw    <= bus.i_rs_data;
                                neg_main <= sign_a ^ sign_b;
                                neg_rem  <= 1'b0;
                                div_zero <= 1'b0;
                                is_div   <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state    <= ST_DIV;
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                                m_reg    <= abs_b;
                                p_hi     <= '0;
                                p_lo     <= abs_a;
                                a_raw    <= bus.i_rs_data;
                                neg_main <= sign_a ^ sign_b;
                                neg_rem  <= sign_a;
                                div_zero <= (bus.i_rt_data == '0);
                                is_div   <= 1'b1;
                            end
                            OP_MTHI: hi_q <= bus.i_rs_data;
                            OP_MTLO: lo_q <= bus.i_rs_data;
                            default: ;  // no-op codes
                        endcase
                    end
                end

                ST_MUL: begin
                    p_hi <= mul_sum[LEN:1];
                    p_lo <= {mul_sum[0], p_lo[LEN-1:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end

                ST_DIV: begin
                    p_hi <= div_ok ? div_diff[LEN-1:0] : div_shift[LEN-1:0];
                    p_lo <= {p_lo[LEN-2:0], div_ok};
                    cnt  <= cnt + 5'd1;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end

                ST_FIX: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int LEN = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    always #5 i_clk = ~i_clk;

    mult_div_unit_if #(.LEN(LEN), .NB_OP(3)) bus ();

    mult_div_unit #(.LEN(LEN), .NB_OP(3)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    task automatic check(input string tag, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Architectural HI/LO behaviour, computed with ordinary 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        case (op)
            OP_MULT: begin
                p = sa * sb;
                {ref_hi, ref_lo} = p;
            end
            OP_MULTU: begin
                p = ua * {32'd0, b};
                {ref_hi, ref_lo} = p;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    ref_lo = 32'hFFFF_FFFF;
                    ref_hi = a;
                end else if (op == OP_DIV) begin
                    p = sa / sb;
                    ref_lo = p[31:0];
                    p = sa % sb;
                    ref_hi = p[31:0];
                end else begin
                    ref_lo = a / b;
                    ref_hi = a % b;
                end
            end
            OP_MTHI: ref_hi = a;
            OP_MTLO: ref_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request and follow it to completion. stall_at > 0 drops
    // i_enable for stall_len cycles starting at that busy cycle; poke sends a
    // second i_start while busy, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len,
                          input bit poke);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          busy_cnt;
        int          exp_len;
        bit          hold_ok;
        bit          done_early;
        prev_hi = ref_hi;
        prev_lo = ref_lo;

        @(negedge i_clk);
        bus.i_op      = op;
        bus.i_rs_data = a;
        bus.i_rt_data = b;
        bus.i_start   = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        model(op, a, b);

        if (op >= OP_MTHI) begin
            check({tag, " hi"}, 64'(bus.o_hi), 64'(ref_hi));
            check({tag, " lo"}, 64'(bus.o_lo), 64'(ref_lo));
            check({tag, " busy"}, 64'(bus.o_busy), 64'd0);
            check({tag, " done"}, 64'(bus.o_done), 64'd0);
            return;
        end

        busy_cnt   = 0;
        hold_ok    = 1'b1;
        done_early = 1'b0;
        while (bus.o_busy === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            if (bus.o_hi !== prev_hi || bus.o_lo !== prev_lo) hold_ok = 1'b0;
            if (bus.o_done !== 1'b0) done_early = 1'b1;
            if (stall_at > 0 && busy_cnt == stall_at) bus.i_enable = 1'b0;
            if (stall_at > 0 && busy_cnt == stall_at + stall_len) bus.i_enable = 1'b1;
            if (poke && busy_cnt == 3) begin
                bus.i_op      = OP_MTHI;
                bus.i_rs_data = 32'hDEAD_BEEF;
                bus.i_start   = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        bus.i_enable = 1'b1;

        exp_len = (stall_at > 0) ? 33 + stall_len : 33;
        check({tag, " busy_len"}, 64'(busy_cnt), 64'(exp_len));
        check({tag, " hold"}, 64'({hold_ok, done_early}), 64'b10);
        check({tag, " done"}, 64'(bus.o_done), 64'd1);
        check({tag, " hi"}, 64'(bus.o_hi), 64'(ref_hi));
        check({tag, " lo"}, 64'(bus.o_lo), 64'(ref_lo));
        @(negedge i_clk);
        check({tag, " done_pulse"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        int          seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          st_at;
        int          st_len;

        bus.i_enable  = 1'b1;
        bus.i_start   = 1'b1;          // reset must override a pending request
        bus.i_op      = OP_MTHI;
        bus.i_rs_data = 32'hA5A5_A5A5;
        bus.i_rt_data = '0;
        i_rst         = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset hi", 64'(bus.o_hi), 64'd0);
        check("reset lo", 64'(bus.o_lo), 64'd0);
        check("reset busy", 64'(bus.o_busy), 64'd0);
        check("reset done", 64'(bus.o_done), 64'd0);
        bus.i_start = 1'b0;
        i_rst       = 1'b1;

        // Directed corner cases.
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 0, 0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 0, 0, 1'b0);
        run_op("divu_stall", OP_DIVU, 32'd100, 32'd7, 10, 5, 1'b1);
        run_op("mult_stall_fix", OP_MULT, 32'h0001_2345, 32'hFFFF_0003, 33, 3, 1'b0);

        // Reset in the middle of a MULTU: no result, no done pulse.
        @(negedge i_clk);
        bus.i_op      = OP_MULTU;
        bus.i_rs_data = 32'h1234_5678;
        bus.i_rt_data = 32'h9ABC_DEF0;
        bus.i_start   = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst  = 1'b1;
        ref_hi = '0;
        ref_lo = '0;
        check("abort hi", 64'(bus.o_hi), 64'd0);
        check("abort lo", 64'(bus.o_lo), 64'd0);
        check("abort busy", 64'(bus.o_busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) seen++;
            @(negedge i_clk);
        end
        check("abort quiet", 64'(seen), 64'd0);

        run_op("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
        run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 0, 0, 1'b0);
        run_op("nop", OP_NOP, 32'h1111_1111, 32'h2222_2222, 0, 0, 1'b0);

        // Random traffic, occasionally stalled, with some zero divisors.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            st_at  = 0;
            st_len = 0;
            if ($urandom_range(0, 3) == 0) begin
                st_at  = $urandom_range(1, 33);
                st_len = $urandom_range(1, 4);
            end
            run_op($sformatf("rand%0d", i), rop, ra, rb, st_at, st_len, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
